// File: rtl/sd_cmd_framer.sv
// ---------------------------------------------------------------------------
// sd_cmd_framer
//
// Sends one 48-bit SD command frame in SPI mode and then polls the card for
// its R1 response byte.
//
// Frame, MSB first on mosi:
//   0, 1, cmd_idx[5:0], cmd_arg[31:0], crc7[6:0], 1
//
// Each frame bit occupies one bit cell of 2*CLK_DIV clk cycles:
//   cell cycle 0 .. CLK_DIV-1            spi_clk = 0
//   cell cycle CLK_DIV .. 2*CLK_DIV-1    spi_clk = 1
// mosi and crc_en change only at cell cycle 1. That is one clk after the
// spi_clk falling edge, so a CRC stage that shifts on the falling edge always
// sees a stable mosi/crc_en pair.
//
// CRC generation (compile-time option, macro SD_CMD_CRC_GEN_EN):
//   defined   : crc_reset pulses for one cycle before the frame. crc_en is
//               high for the cells of bits 0..39, so the external CRC stage
//               sees exactly 40 falling edges with crc_en = 1. crc_in[6:0] is
//               loaded at cell 40, cycle 1 and shifted out as bits 40..46.
//   undefined : crc_reset and crc_en stay 0, crc_in is ignored and the crc7
//               field is sent as 7'h7F. Frame timing is identical.
//
// Response phase: mosi is held at 1 while spi_clk keeps toggling. miso is
// sampled at cell cycle CLK_DIV (the spi_clk rising edge) and shifted in MSB
// first. The first byte with bit7 = 0 becomes resp. If RESP_MAX_BYTES bytes
// all have bit7 = 1, resp is set to 8'hFF and timeout is raised.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE,
// and cmd_idx/cmd_arg are captured in that same cycle. busy covers the
// interval from acceptance to completion. done pulses for one cycle in FIN,
// which is also the cycle in which busy drops. resp and timeout stay valid
// until the next accepted start.
//
// Parameters
//   CLK_DIV         clk cycles per spi_clk half-period (>= 2)
//   RESP_MAX_BYTES  response bytes polled before timeout (1..255)
//
// Ports
//   clk          system clock, rising edge only
//   reset_n      synchronous active-low reset
//   start        one-cycle command request (sampled in IDLE only)
//   cmd_idx      6-bit command index
//   cmd_arg      32-bit command argument
//   cs_n         SPI chip select, low from SEND entry until FIN
//   spi_clk      SPI clock, idles low
//   mosi         SPI data to the card and to the CRC stage, idles high
//   miso         SPI data from the card
//   crc_reset    one-cycle active-high clear to the CRC stage
//   crc_en       CRC stage shift enable
//   crc_in       CRC register from the CRC stage (bits [6:0] used)
//   busy         command in progress
//   done         one-cycle completion pulse
//   timeout      no valid R1 byte within RESP_MAX_BYTES
//   resp         R1 response byte (8'hFF after a timeout)
//   dbg_state    current FSM state (IDLE=0, CLR=1, SEND=2, RESP=3, FIN=4)
// ---------------------------------------------------------------------------
module sd_cmd_framer #(
    parameter int CLK_DIV        = 4,
    parameter int RESP_MAX_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        cs_n,
    output logic        spi_clk,
    output logic        mosi,
    input  logic        miso,
    output logic        crc_reset,
    output logic        crc_en,
    input  logic [7:0]  crc_in,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  resp,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_SEND = 3'd2,
        ST_RESP = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Cell cycle counter width and the cell cycles of interest.
    localparam int             CW           = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0]  CYC_ONE      = CW'(1);
    localparam logic [CW-1:0]  CYC_RISE_PRE = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  CYC_SAMPLE   = CW'(CLK_DIV);
    localparam logic [CW-1:0]  CYC_LAST     = CW'(2 * CLK_DIV - 1);
    localparam logic [7:0]     LAST_BYTE    = 8'(RESP_MAX_BYTES - 1);
    localparam logic [5:0]     CRC_BIT      = 6'd40;
    localparam logic [5:0]     LAST_BIT     = 6'd47;

    state_t          state;
    logic [47:0]     frame_sh;   // frame bits still to send, next bit in [47]
    logic [CW-1:0]   cyc;        // position inside the current bit cell
    logic [5:0]      bit_cnt;    // frame bit index during SEND
    logic [2:0]      rbit;       // bit index inside the current response byte
    logic [7:0]      rx;         // response shift register
    logic [7:0]      byte_cnt;   // response bytes already rejected
    logic [6:0]      crc7_src;   // value sent in the crc7 field

`ifdef SD_CMD_CRC_GEN_EN
    logic unused_crc_bits;
    assign crc7_src        = crc_in[6:0];
    assign unused_crc_bits = crc_in[7];
`else
    logic unused_crc_bits;
    assign crc7_src        = 7'h7F;
    assign unused_crc_bits = ^crc_in;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cs_n      <= 1'b1;
            spi_clk   <= 1'b0;
            mosi      <= 1'b1;
            crc_en    <= 1'b0;
            crc_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            resp      <= 8'hFF;
            frame_sh  <= '0;
            cyc       <= '0;
            bit_cnt   <= '0;
            rbit      <= '0;
            rx        <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // The crc7 slot is loaded with all ones here. With CRC
                        // generation enabled it is overwritten at bit 40.
                        frame_sh <= {2'b01, cmd_idx, cmd_arg, 7'h7F, 1'b1};
                        busy     <= 1'b1;
                        timeout  <= 1'b0;
`ifdef SD_CMD_CRC_GEN_EN
                        crc_reset <= 1'b1;
`endif
                        state    <= ST_CLR;
                    end
                end

                ST_CLR: begin
                    crc_reset <= 1'b0;
                    cs_n      <= 1'b0;
                    spi_clk   <= 1'b0;
                    cyc       <= '0;
                    bit_cnt   <= '0;
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    // Cell cycle 1: present the next bit and update crc_en.
                    if (cyc == '0) begin
                        if (bit_cnt == CRC_BIT) begin
                            // The CRC stage shifted bit 39 on the falling edge
                            // that opened this cell, so crc_in is now final.
                            // Its 7 bits replace the all-ones crc7 slot. The
                            // stop bit stays just behind them.
                            mosi     <= crc7_src[6];
                            frame_sh <= {crc7_src[5:0], frame_sh[40:0], 1'b0};
                        end else begin
                            mosi     <= frame_sh[47];
                            frame_sh <= {frame_sh[46:0], 1'b0};
                        end
`ifdef SD_CMD_CRC_GEN_EN
                        crc_en <= (bit_cnt < CRC_BIT);
`endif
                    end

                    if (cyc == CYC_RISE_PRE) begin
                        spi_clk <= 1'b1;
                    end

                    if (cyc == CYC_LAST) begin
                        cyc     <= '0;
                        spi_clk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            mosi     <= 1'b1;
                            rbit     <= '0;
                            byte_cnt <= '0;
                            state    <= ST_RESP;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else begin
                        cyc <= cyc + CYC_ONE;
                    end
                end

                ST_RESP: begin
                    mosi   <= 1'b1;
                    crc_en <= 1'b0;

                    if (cyc == CYC_RISE_PRE) begin
                        spi_clk <= 1'b1;
                    end

                    if (cyc == CYC_SAMPLE) begin
                        rx <= {rx[6:0], miso};
                    end

                    // A byte is judged only at the end of its last cell, so
                    // the final spi_clk high phase keeps its full width.
                    if (cyc == CYC_LAST) begin
                        cyc     <= '0;
                        spi_clk <= 1'b0;
                        rbit    <= rbit + 3'd1;
                        if (rbit == 3'd7) begin
                            if (!rx[7]) begin
                                resp    <= rx;
                                timeout <= 1'b0;
                                cs_n    <= 1'b1;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state   <= ST_FIN;
                            end else if (byte_cnt == LAST_BYTE) begin
                                resp    <= 8'hFF;
                                timeout <= 1'b1;
                                cs_n    <= 1'b1;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state   <= ST_FIN;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end
                    end else begin
                        cyc <= cyc + CYC_ONE;
                    end
                end

                ST_FIN: begin
                    done    <= 1'b0;
                    cs_n    <= 1'b1;
                    spi_clk <= 1'b0;
                    mosi    <= 1'b1;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_framer.sv
module tb_sd_cmd_framer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic        cs_n, spi_clk, mosi;
    logic        miso = 1'b1;
    logic        crc_reset, crc_en;
    logic [7:0]  crc_in;
    logic        busy, done, timeout;
    logic [7:0]  resp;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    sd_cmd_framer #(.CLK_DIV(4), .RESP_MAX_BYTES(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .cs_n(cs_n), .spi_clk(spi_clk), .mosi(mosi), .miso(miso),
        .crc_reset(crc_reset), .crc_en(crc_en), .crc_in(crc_in),
        .busy(busy), .done(done), .timeout(timeout), .resp(resp),
        .dbg_state(dbg_state)
    );

    // ---------------- CRC7 stage model (x^7 + x^3 + 1) ----------------
    logic [6:0] crc_q = '0;
    always @(negedge spi_clk or posedge crc_reset) begin
        if (crc_reset)
            crc_q <= '0;
        else if (crc_en)
            crc_q <= {crc_q[5:0], 1'b0} ^ ({7{crc_q[6] ^ mosi}} & 7'h09);
    end
    assign crc_in = {1'b0, crc_q};

    // ---------------- bus monitor ----------------
    int          rise_cnt = 0;
    int          fall_en_cnt = 0;
    int          crst_cnt = 0;
    int          en_cyc = 0;
    int          done_cnt = 0;
    int          mosi_bad = 0;
    logic [47:0] frame_bits = '0;
    logic        prev_cs_n = 1'b1, prev_spi = 1'b0, prev2_spi = 1'b0, prev_mosi = 1'b1;

    always @(posedge clk) begin
        if (!cs_n && prev_cs_n) begin
            rise_cnt    = 0;
            fall_en_cnt = 0;
            frame_bits  = '0;
        end
        if (!cs_n && spi_clk && !prev_spi) begin
            if (rise_cnt < 48) frame_bits = {frame_bits[46:0], mosi};
            rise_cnt++;
        end
        if (!cs_n && !spi_clk && prev_spi && crc_en) fall_en_cnt++;
        // mosi may only move in the second low cycle of a cell
        if (!cs_n && !prev_cs_n && (mosi != prev_mosi) &&
            !(!spi_clk && !prev_spi && (prev2_spi || rise_cnt == 0))) mosi_bad++;
        if (crc_reset) crst_cnt++;
        if (crc_en) en_cyc++;
        if (done) done_cnt++;
        prev2_spi = prev_spi;
        prev_spi  = spi_clk;
        prev_cs_n = cs_n;
        prev_mosi = mosi;
    end

    // ---------------- card model: miso bit stream ----------------
    logic [63:0] miso_stream = '1;
    always @(negedge clk) begin
        if (cs_n) begin
            miso = 1'b1;
        end else if (!spi_clk && rise_cnt >= 48) begin
            if (rise_cnt - 48 < 64) miso = miso_stream[63 - (rise_cnt - 48)];
            else miso = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [63:0] miso;   // response bytes, first byte in [63:56]
        logic [47:0] frame;  // frame with generated CRC
        logic [7:0]  resp;
        logic        tmo;
        logic [7:0]  nclk;   // response clocks
    } vec_t;

    vec_t vecs [5];

`ifdef SD_CMD_CRC_GEN_EN
    localparam int EXP_FALL_EN = 40;
    localparam int EXP_EN_CYC  = 320;
    localparam int EXP_CRST    = 1;
`else
    localparam int EXP_FALL_EN = 0;
    localparam int EXP_EN_CYC  = 0;
    localparam int EXP_CRST    = 0;
`endif

    function automatic logic [47:0] exp_frame(input logic [47:0] f);
`ifdef SD_CMD_CRC_GEN_EN
        return f;
`else
        return {f[47:8], 8'hFF};
`endif
    endfunction

    task automatic wait_cond_rise(input int target, input string name);
        int n = 0;
        while (rise_cnt != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (rise_cnt == target), 1'b1);
    endtask

    task automatic wait_cs_low(input string name);
        int n = 0;
        while (cs_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, cs_n, 1'b0);
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic run_frame(input vec_t v, input bit poke, input string tag);
        int n = 0;
        int d0, c0, e0, b0;
        miso_stream = v.miso;
        @(negedge clk);
        cmd_idx = v.idx;
        cmd_arg = v.arg;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cmd_idx = 6'($urandom_range(0, 63));
        cmd_arg = $urandom;
        d0 = done_cnt; c0 = crst_cnt; e0 = en_cyc; b0 = mosi_bad;
        chk({tag, " busy_after_start"}, busy, 1'b1);
        chk({tag, " timeout_cleared"}, timeout, 1'b0);
        if (poke) begin
            wait_cs_low({tag, " cs_low"});
            wait_cond_rise(10, {tag, " reach_bit10"});
            cmd_idx = 6'h11;
            cmd_arg = 32'hFFFF_FFFF;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            chk({tag, " busy_mid_frame"}, busy, 1'b1);
        end
        while (!done && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done_seen"}, done, 1'b1);
        chk({tag, " cs_n_at_done"}, cs_n, 1'b1);
        chk({tag, " busy_at_done"}, busy, 1'b0);
        chk({tag, " spi_clk_at_done"}, spi_clk, 1'b0);
        chk({tag, " mosi_at_done"}, mosi, 1'b1);
        chk({tag, " frame"}, frame_bits, exp_frame(v.frame));
        chk({tag, " resp"}, resp, v.resp);
        chk({tag, " timeout"}, timeout, v.tmo);
        chk({tag, " resp_clocks"}, rise_cnt - 48, v.nclk);
        chk({tag, " crc_en_falls"}, fall_en_cnt, EXP_FALL_EN);
        chk({tag, " crc_en_cycles"}, en_cyc - e0, EXP_EN_CYC);
        chk({tag, " crc_reset_cycles"}, crst_cnt - c0, EXP_CRST);
        chk({tag, " mosi_timing"}, mosi_bad - b0, 0);
        @(negedge clk);
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " done_dropped"}, done, 1'b0);
        chk({tag, " back_idle"}, dbg_state, 3'd0);
        chk({tag, " resp_hold"}, resp, v.resp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cs_n"}, cs_n, 1'b1);
        chk({tag, " spi_clk"}, spi_clk, 1'b0);
        chk({tag, " mosi"}, mosi, 1'b1);
        chk({tag, " crc_en"}, crc_en, 1'b0);
        chk({tag, " crc_reset"}, crc_reset, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " timeout"}, timeout, 1'b0);
        chk({tag, " resp"}, resp, 8'hFF);
        chk({tag, " state"}, dbg_state, 3'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        vecs[0] = '{6'd0,  32'h0000_0000, 64'hFFFF_01FF_FFFF_FFFF, 48'h40_0000_0000_95, 8'h01, 1'b0, 8'd24};
        vecs[1] = '{6'd8,  32'h0000_01AA, 64'h01FF_FFFF_FFFF_FFFF, 48'h48_0000_01AA_87, 8'h01, 1'b0, 8'd8};
        vecs[2] = '{6'd0,  32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 48'h40_0000_0000_95, 8'hFF, 1'b1, 8'd64};
        vecs[3] = '{6'd55, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FF7F, 48'h77_0000_0000_65, 8'h7F, 1'b0, 8'd64};
        vecs[4] = '{6'd41, 32'h4000_0000, 64'hFF05_FFFF_FFFF_FFFF, 48'h69_4000_0000_77, 8'h05, 1'b0, 8'd16};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cs_n", cs_n, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // start while busy is ignored; frame must stay CMD8
        run_frame(vecs[1], 1'b1, "poke");
        repeat (30) @(negedge clk);
        chk("poke_no_second_frame", cs_n, 1'b1);

        // reset in the middle of a frame
        d0 = done_cnt;
        miso_stream = '1;
        @(negedge clk);
        cmd_idx = 6'd0;
        cmd_arg = 32'h0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_cs_low("abort cs_low");
        wait_cond_rise(20, "abort reach_bit20");
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_cs_idle", cs_n, 1'b1);
        run_frame(vecs[0], 1'b0, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_cmd_framer.md
SD_CMD_FRAMER -- requirements
Module: sd_cmd_framer

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per spi_clk half-period; the minimum legal value is 2.
REQ-002 Parameter RESP_MAX_BYTES, default 8, meaning response bytes polled before timeout; the legal range is 1..255.
REQ-003 clk  input  1  system clock, the only clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to send one command; sampled only in IDLE.
REQ-006 cmd_idx  input  6  command index; cmd_arg  input  32  argument; both captured on accepted start.
REQ-007 cs_n, spi_clk, mosi  output  1 each  SPI bus to the card and to the CRC stage.
REQ-008 miso  input  1  card data.
REQ-009 crc_reset  output  1  active-high clear to the downstream CRC stage; crc_en  output  1  CRC stage enable.
REQ-010 crc_in  input  8  CRC register from the CRC stage; only bits [6:0] are used (CRC7).
REQ-011 busy  output  1; done  output  1 (one-cycle pulse); timeout  output  1; resp  output  8  R1 response byte.

Function
REQ-012 States SHALL be IDLE, CLR, SEND, RESP and FIN.
REQ-013 IDLE: on start=1, latch cmd_idx/cmd_arg, set busy=1, assert crc_reset for exactly one cycle (CLR), then enter SEND; start while busy=1 SHALL be ignored.
REQ-014 Frame SHALL be 48 bits MSB-first: 0, 1, cmd_idx[5:0], cmd_arg[31:0], crc7[6:0], 1; cs_n SHALL be 0 from SEND entry until FIN.
REQ-015 Bit cell = 2*CLK_DIV cycles; spi_clk SHALL be 0 for cell cycles 0..CLK_DIV-1 and 1 for CLK_DIV..2*CLK_DIV-1, and SHALL idle at 0.
REQ-016 mosi SHALL change only at cell cycle 1, one clk after the spi_clk falling edge, giving the CRC stage one cycle of hold.
REQ-017 crc_en SHALL update at cell cycle 1 and equal 1 exactly for cells of bits 0..39, so that 40 falling edges are seen with crc_en=1.
REQ-018 crc_in[6:0] SHALL be captured at cell 40 cycle 1 and shifted out as bits 40..46.
REQ-019 RESP: mosi=1, crc_en=0; spi_clk keeps toggling; miso SHALL be sampled at cell cycle CLK_DIV (spi_clk rising) and shifted MSB-first into an 8-bit register.
REQ-020 After each complete byte: if its bit7=0, load resp with it, set timeout=0 and enter FIN; else increment the byte count.
REQ-021 When the byte count reaches RESP_MAX_BYTES with no bit7=0 byte, set resp=8'hFF and timeout=1, then enter FIN.
REQ-022 FIN (one cycle): cs_n=1, spi_clk=0, mosi=1, done=1, busy=0, then return to IDLE; resp and timeout SHALL hold until the next accepted start.
REQ-023 On an accepted start, timeout SHALL clear to 0.

Reset
REQ-024 reset_n=0 at a clk edge SHALL force IDLE with cs_n=1, spi_clk=0, mosi=1, crc_en=0, crc_reset=0, busy=0, done=0, timeout=0 and resp=8'hFF.
REQ-025 Reset mid-frame SHALL abort with no done pulse; the first start after release SHALL send a complete, correct frame.

Configuration
REQ-026 With macro SD_CMD_CRC_GEN_EN defined, crc7 SHALL come from crc_in per REQ-017/018.
REQ-027 Without SD_CMD_CRC_GEN_EN, crc_reset and crc_en SHALL be tied 0, crc_in SHALL be ignored, the crc7 field SHALL be 7'h7F, and all timing SHALL be unchanged.

Verification
REQ-028 SD_CMD_CRC_GEN_EN with a CRC stage model: cmd_idx=0, cmd_arg=0 -> mosi bytes 40 00 00 00 00 95; 40 crc_en falling edges; cs_n low throughout.
REQ-029 SD_CMD_CRC_GEN_EN: cmd_idx=8, cmd_arg=32'h000001AA -> mosi bytes 48 00 00 01 AA 87.
REQ-030 miso bytes FF, FF, 01 after the frame -> resp=8'h01, timeout=0, done after the 3rd byte, cs_n=1 next.
REQ-031 miso held 1, RESP_MAX_BYTES=8 -> exactly 64 response clocks, resp=8'hFF, timeout=1, one done pulse.
REQ-032 start pulsed at frame bit 10 -> ignored and frame unchanged; reset_n=0 at bit 20 -> outputs at reset values, no done, next CMD0 correct.
REQ-033 SD_CMD_CRC_GEN_EN undefined: cmd_idx=0 -> last mosi byte FF; crc_en and crc_reset never asserted.
